// File: rtl/mem_access_pkg.sv
// Shared op codes, FSM encoding and request record for the load/store sequencer.
`timescale 1ns/1ps
package mem_access_pkg;

   typedef enum logic [2:0] {
      OP_LW   = 3'b000,
      OP_LH   = 3'b001,
      OP_LB   = 3'b010,
      OP_SW   = 3'b011,
      OP_SH   = 3'b100,
      OP_SB   = 3'b101,
      OP_RSV6 = 3'b110,
      OP_RSV7 = 3'b111
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_WAIT = 3'd2,
      S_WR   = 3'd3,
      S_DONE = 3'd4
   } state_e;

   // Wide enough for RD_LAT-1 with RD_LAT up to 7.
   localparam int RD_CNT_W = 3;

   typedef struct packed {
      op_e         op;
      logic [31:0] addr;
      logic [31:0] b;
   } mem_req_t;

   function automatic logic is_load(input op_e op);
      return (op == OP_LW) || (op == OP_LH) || (op == OP_LB);
   endfunction

   function automatic logic is_reserved(input op_e op);
      return (op == OP_RSV6) || (op == OP_RSV7);
   endfunction

   function automatic logic misaligned(input op_e op, input logic [1:0] a);
      logic bad;
      bad = 1'b0;
      case (op)
         OP_LW, OP_SW: bad = (a != 2'b00);
         OP_LH, OP_SH: bad = a[0];
         default:      bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_access_unit_byte_lane_merge.sv
// Lane merge for RMW stores and zero-extension for loads; always the low half/byte of the word.
`timescale 1ns/1ps
module byte_lane_merge
   import mem_access_pkg::*;
(
   input  op_e         op,
   input  logic [31:0] rdata,
   input  logic [31:0] b_data,
   output logic [31:0] wdata,
   output logic [31:0] load_val
);

   always_comb begin
      wdata    = b_data;
      load_val = rdata;
      case (op)
         OP_LH:   load_val = {16'h0, rdata[15:0]};
         OP_LB:   load_val = {24'h0, rdata[7:0]};
         OP_SH:   wdata    = {rdata[31:16], b_data[15:0]};
         OP_SB:   wdata    = {rdata[31:8],  b_data[7:0]};
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Multicycle load/store sequencer (IDLE/RD/WAIT/WR/DONE) for the unified memory.
// Optional MISALIGN_EXC_EN: reject misaligned word/half requests with a one-cycle exc flag.
`timescale 1ns/1ps
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] b_data,
   input  logic [31:0] mem_rdata,
   output logic [31:0] mem_addr,
   output logic        mem_wr,
   output logic [31:0] mem_wdata,
   output logic [31:0] load_data,
   output logic        busy,
   output logic        done,
   output logic        exc
);

   localparam logic [RD_CNT_W-1:0] WAIT_INIT = RD_CNT_W'(RD_LAT - 1);

   state_e                state_q, state_d;
   mem_req_t              req_q;
   logic [RD_CNT_W-1:0]   wait_cnt;
   logic                  accept, wait_last, bad_align;
   logic [31:0]           merge_wdata, merge_load;
   op_e                   op_in;

   assign op_in     = op_e'(op);
   assign accept    = (state_q == S_IDLE) && start;
   assign wait_last = (state_q == S_WAIT) && (wait_cnt == '0);

`ifdef MISALIGN_EXC_EN
   logic exc_q;
   assign bad_align = misaligned(op_in, addr[1:0]);
   assign exc       = exc_q && (state_q == S_DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       exc_q <= 1'b0;
      else if (accept) exc_q <= bad_align;
   end
`else
   assign bad_align = 1'b0;
   assign exc       = 1'b0;
`endif

   byte_lane_merge u_merge (
      .op       (req_q.op),
      .rdata    (mem_rdata),
      .b_data   (req_q.b),
      .wdata    (merge_wdata),
      .load_val (merge_load)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (bad_align || is_reserved(op_in)) state_d = S_DONE;
               else if (op_in == OP_SW)             state_d = S_WR;
               else                                 state_d = S_RD;
            end
         end
         S_RD:   state_d = S_WAIT;
         S_WAIT: if (wait_cnt == '0) state_d = is_load(req_q.op) ? S_DONE : S_WR;
         S_WR:   state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Strobes decode straight from the state register so reset kills them asynchronously.
   assign mem_wr   = (state_q == S_WR);
   assign done     = (state_q == S_DONE);
   assign busy     = (state_q != S_IDLE);
   assign mem_addr = req_q.addr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         req_q     <= '0;
         wait_cnt  <= '0;
         mem_wdata <= '0;
         load_data <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            req_q.op   <= op_in;
            req_q.addr <= addr;
            req_q.b    <= b_data;
            if (op_in == OP_SW && !bad_align) mem_wdata <= b_data;
         end
         if (state_q == S_RD) wait_cnt <= WAIT_INIT;
         if (state_q == S_WAIT) begin
            if (wait_last) begin
               if (is_load(req_q.op)) load_data <= merge_load;
               else                   mem_wdata <= merge_wdata;
            end else begin
               wait_cnt <= wait_cnt - 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a one-cycle-latency memory model.
`timescale 1ns/1ps
module tb_mem_access_unit;
   import mem_access_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op = 3'b000;
   logic [31:0] addr = '0;
   logic [31:0] b_data = '0;
   logic [31:0] mem_rdata = '0;
   logic [31:0] mem_addr, mem_wdata, load_data;
   logic        mem_wr, busy, done, exc;

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;
   logic [31:0] mem [0:63];

   mem_access_unit #(.RD_LAT(1)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr),
      .b_data(b_data), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
      .mem_wr(mem_wr), .mem_wdata(mem_wdata), .load_data(load_data),
      .busy(busy), .done(done), .exc(exc)
   );

   always #5 clk = ~clk;

   // Memory: registered read (latency 1), write on mem_wr; contents reloaded while reset is high.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
         mem[4]  <= 32'hCAFE8001;
         mem[16] <= 32'h12345678;
         mem[32] <= 32'h11223344;
      end else begin
         mem_rdata <= mem[mem_addr[7:2]];
         if (mem_wr) begin
            mem[mem_addr[7:2]] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      op = o; addr = a; b_data = b; start = 1'b1;
   endtask

   initial begin
      int w0, nd, d1, d2, busy_bad;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_wr", 32'(mem_wr), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_exc", 32'(exc), 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_load", load_data, 0);
      reset = 1'b0;
      tick();
      chk("idle_busy", 32'(busy), 0);

      // SW: write in cycle 1, done in cycle 2
      issue(OP_SW, 32'h40, 32'hDEADBEEF);
      tick(); start = 1'b0;
      chk("sw_c1_wr", 32'(mem_wr), 1);
      chk("sw_c1_wdata", mem_wdata, 32'hDEADBEEF);
      chk("sw_c1_addr", mem_addr, 32'h40);
      chk("sw_c1_done", 32'(done), 0);
      tick();
      chk("sw_c2_done", 32'(done), 1);
      chk("sw_c2_wr", 32'(mem_wr), 0);
      tick();
      chk("sw_c3_busy", 32'(busy), 0);
      chk("sw_mem", mem[16], 32'hDEADBEEF);

      // SB read-modify-write: RD 1, WAIT 2, WR 3, DONE 4
      w0 = wr_cnt;
      issue(OP_SB, 32'h80, 32'h000000AA);
      tick(); start = 1'b0;
      chk("sb_c1_busy", 32'(busy), 1);
      chk("sb_c1_wr", 32'(mem_wr), 0);
      tick();
      chk("sb_c2_wr", 32'(mem_wr), 0);
      tick();
      chk("sb_c3_wr", 32'(mem_wr), 1);
      chk("sb_c3_wdata", mem_wdata, 32'h112233AA);
      tick();
      chk("sb_c4_done", 32'(done), 1);
      chk("sb_c4_wr", 32'(mem_wr), 0);
      tick();
      chk("sb_mem", mem[32], 32'h112233AA);
      chk("sb_wr_pulses", 32'(wr_cnt - w0), 1);

      // LH then LB on 0xCAFE8001
      issue(OP_LH, 32'h10, 32'h0);
      tick(); start = 1'b0;
      tick();
      chk("lh_c2_done", 32'(done), 0);
      tick();
      chk("lh_c3_done", 32'(done), 1);
      chk("lh_load", load_data, 32'h00008001);
      tick();
      issue(OP_LB, 32'h10, 32'h0);
      tick(); start = 1'b0;
      tick(); tick();
      chk("lb_c3_done", 32'(done), 1);
      chk("lb_load", load_data, 32'h00000001);
      tick();

      // reset during SH WAIT: everything back to 0, no write
      w0 = wr_cnt;
      issue(OP_SH, 32'h80, 32'h00005555);
      tick(); start = 1'b0;
      tick();
      chk("shrst_wait_busy", 32'(busy), 1);
      #2 reset = 1'b1;
      #1;
      chk("shrst_busy", 32'(busy), 0);
      chk("shrst_wr", 32'(mem_wr), 0);
      chk("shrst_done", 32'(done), 0);
      chk("shrst_load", load_data, 0);
      chk("shrst_addr", mem_addr, 0);
      chk("shrst_wdata", mem_wdata, 0);
      tick();
      reset = 1'b0;
      tick();
      chk("shrst_idle", 32'(busy), 0);
      chk("shrst_no_wr", 32'(wr_cnt - w0), 0);

      // start held for 8 cycles with LW: two operations, second accepted at cycle 4
      issue(OP_LW, 32'h10, 32'h0);
      nd = 0; d1 = -1; d2 = -1; busy_bad = 0;
      for (int c = 1; c <= 14; c++) begin
         tick();
         if (c == 8) start = 1'b0;
         if (done) begin
            nd++;
            if (d1 < 0) d1 = c; else d2 = c;
         end
         if (c == 4) chk("hold_c4_idle", 32'(busy), 0);
         else if (c < 8 && !busy) busy_bad++;
      end
      chk("hold_ops", 32'(nd), 2);
      chk("hold_done1", 32'(d1), 3);
      chk("hold_done2", 32'(d2), 7);
      chk("hold_busy", 32'(busy_bad), 0);
      chk("hold_load", load_data, 32'hCAFE8001);

      // reserved op: done in cycle 1, no memory write
      w0 = wr_cnt;
      issue(3'b110, 32'h80, 32'hFFFFFFFF);
      tick(); start = 1'b0;
      chk("rsv_c1_done", 32'(done), 1);
      chk("rsv_c1_wr", 32'(mem_wr), 0);
      tick();
      chk("rsv_idle", 32'(busy), 0);
      chk("rsv_no_wr", 32'(wr_cnt - w0), 0);

      // LW at misaligned 0x42
      w0 = wr_cnt;
      issue(OP_LW, 32'h42, 32'h0);
      tick(); start = 1'b0;
`ifdef MISALIGN_EXC_EN
      chk("mis_c1_done", 32'(done), 1);
      chk("mis_c1_exc", 32'(exc), 1);
      tick();
      chk("mis_c2_busy", 32'(busy), 0);
      chk("mis_c2_exc", 32'(exc), 0);
      chk("mis_load", load_data, 32'hCAFE8001);
`else
      chk("mis_c1_done", 32'(done), 0);
      chk("mis_c1_exc", 32'(exc), 0);
      tick(); tick();
      chk("mis_c3_done", 32'(done), 1);
      chk("mis_c3_exc", 32'(exc), 0);
      chk("mis_load", load_data, 32'h12345678);
`endif
      chk("mis_no_wr", 32'(wr_cnt - w0), 0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
